// File: rtl/hazard_sequencer.sv
// Pipeline hazard sequencer: bubbles, IF/ID flushes and data-memory freezes for the 5-stage core.
// Optional performance counters are built only when HAZARD_PERF_EN is defined.
module hazard_sequencer #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1_ID,
  input  logic [4:0]       rs2_ID,
  input  logic             useRs1_ID,
  input  logic             useRs2_ID,
  input  logic             isBJ_ID,
  input  logic             bjTaken_ID,
  input  logic [4:0]       rd_EX,
  input  logic             regWrite_EX,
  input  logic             memRead_EX,
  input  logic [4:0]       rd_MEM,
  input  logic             memRead_MEM,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pcWrite,
  output logic             IFIDWrite,
  output logic             IDEXWrite,
  output logic             EXMEMWrite,
  output logic             MEMWBWrite,
  output logic             IFIDFlush,
  output logic             IDEXFlush,
  output logic [CNT_W-1:0] stallCycles,
  output logic [CNT_W-1:0] flushCount
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    STALL    = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  typedef struct packed {
    logic pc;
    logic ifid;
    logic idex;
    logic exmem;
    logic memwb;
    logic ifid_flush;
    logic idex_flush;
  } ctl_t;

  localparam ctl_t CTL_RUN    = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  localparam ctl_t CTL_BUBBLE = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
  localparam ctl_t CTL_FREEZE = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam ctl_t CTL_RESET  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  state_t     state, state_next;
  state_t     ret, ret_next;
  state_t     eff;
  logic [1:0] cnt, cnt_next;
  ctl_t       ctl;

  logic hit_ex, hit_mem;
  logic luse, bj_ex, bj_ld_ex, bj_ld_mem;
  logic [1:0] n_bub;
  logic mem_stall;

  // A source match only matters for registers the ID instruction really reads; x0 never hazards.
  assign hit_ex  = (rd_EX != 5'd0) &&
                   ((useRs1_ID && (rs1_ID == rd_EX)) || (useRs2_ID && (rs2_ID == rd_EX)));
  assign hit_mem = (rd_MEM != 5'd0) &&
                   ((useRs1_ID && (rs1_ID == rd_MEM)) || (useRs2_ID && (rs2_ID == rd_MEM)));

  assign luse      = memRead_EX && hit_ex;
  assign bj_ex     = isBJ_ID && regWrite_EX && !memRead_EX && hit_ex;
  assign bj_ld_ex  = isBJ_ID && memRead_EX && hit_ex;
  assign bj_ld_mem = isBJ_ID && memRead_MEM && hit_mem;

  assign n_bub = bj_ld_ex                       ? 2'd2 :
                 (luse || bj_ex || bj_ld_mem)   ? 2'd1 : 2'd0;

  assign mem_stall = dmem_req && !dmem_ready;

  // On release from MEM_WAIT the cycle behaves exactly like the state that was frozen.
  assign eff = ((state == MEM_WAIT) && dmem_ready) ? ret : state;

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    ctl        = CTL_RUN;
    state_next = state;
    cnt_next   = cnt;
    ret_next   = ret;

    case (eff)
      RUN: begin
        if (mem_stall) begin
          ctl        = CTL_FREEZE;
          ret_next   = RUN;
          state_next = MEM_WAIT;
        end else if (n_bub != 2'd0) begin
          ctl = CTL_BUBBLE;
          if (n_bub == 2'd2) begin
            cnt_next   = 2'd1;
            state_next = STALL;
          end else begin
            state_next = RUN;
          end
        end else begin
          ctl.ifid_flush = bjTaken_ID;
          state_next     = RUN;
        end
      end

      STALL: begin
        if (mem_stall) begin
          ctl        = CTL_FREEZE;
          ret_next   = STALL;
          state_next = MEM_WAIT;
        end else begin
          ctl        = CTL_BUBBLE;
          cnt_next   = (cnt == 2'd0) ? 2'd0 : cnt - 2'd1;
          state_next = (cnt <= 2'd1) ? RUN : STALL;
        end
      end

      MEM_WAIT: begin
        ctl = CTL_FREEZE;
      end

      default: begin
        ctl        = CTL_FREEZE;
        state_next = RUN;
        cnt_next   = 2'd0;
        ret_next   = RUN;
      end
    endcase

    if (rst) begin
      ctl = CTL_RESET;
    end
  end

  assign pcWrite    = ctl.pc;
  assign IFIDWrite  = ctl.ifid;
  assign IDEXWrite  = ctl.idex;
  assign EXMEMWrite = ctl.exmem;
  assign MEMWBWrite = ctl.memwb;
  assign IFIDFlush  = ctl.ifid_flush;
  assign IDEXFlush  = ctl.idex_flush;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      cnt   <= 2'd0;
      ret   <= RUN;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      ret   <= ret_next;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_q, flush_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!ctl.pc)        stall_q <= stall_q + CNT_W'(1);
      if (ctl.ifid_flush) flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign stallCycles = stall_q;
  assign flushCount  = flush_q;
`else
  assign stallCycles = '0;
  assign flushCount  = '0;
`endif

endmodule

// File: tb/tb_hazard_sequencer.sv
// Self-checking bench for hazard_sequencer: directed test-plan scenarios plus randomized
// traffic, all checked every cycle against a bubble-count/wait-flag model of the sequencer.
module tb_hazard_sequencer;
  localparam int CNT_W = 32;
`ifdef HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // {pcWrite, IFIDWrite, IDEXWrite, EXMEMWrite, MEMWBWrite, IFIDFlush, IDEXFlush}
  localparam logic [6:0] V_RUN    = 7'b1111100;
  localparam logic [6:0] V_TAKEN  = 7'b1111110;
  localparam logic [6:0] V_BUBBLE = 7'b0011101;
  localparam logic [6:0] V_FREEZE = 7'b0000000;
  localparam logic [6:0] V_RESET  = 7'b0000011;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] rs1_ID, rs2_ID, rd_EX, rd_MEM;
  logic useRs1_ID, useRs2_ID, isBJ_ID, bjTaken_ID;
  logic regWrite_EX, memRead_EX, memRead_MEM, dmem_req, dmem_ready;
  logic pcWrite, IFIDWrite, IDEXWrite, EXMEMWrite, MEMWBWrite, IFIDFlush, IDEXFlush;
  logic [CNT_W-1:0] stallCycles, flushCount;

  always #5 clk = ~clk;

  hazard_sequencer #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .useRs1_ID(useRs1_ID), .useRs2_ID(useRs2_ID),
    .isBJ_ID(isBJ_ID), .bjTaken_ID(bjTaken_ID),
    .rd_EX(rd_EX), .regWrite_EX(regWrite_EX), .memRead_EX(memRead_EX),
    .rd_MEM(rd_MEM), .memRead_MEM(memRead_MEM),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pcWrite(pcWrite), .IFIDWrite(IFIDWrite), .IDEXWrite(IDEXWrite),
    .EXMEMWrite(EXMEMWrite), .MEMWBWrite(MEMWBWrite),
    .IFIDFlush(IFIDFlush), .IDEXFlush(IDEXFlush),
    .stallCycles(stallCycles), .flushCount(flushCount)
  );

  wire [6:0] ctl_vec = {pcWrite, IFIDWrite, IDEXWrite, EXMEMWrite, MEMWBWrite, IFIDFlush, IDEXFlush};

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
  endtask

  // ---------------- behavioural model ----------------
  int               m_left = 0;      // bubbles still owed after the current one
  bit               m_wait = 1'b0;   // a memory freeze is in progress
  logic [CNT_W-1:0] m_stall = '0;
  logic [CNT_W-1:0] m_flush = '0;
  bit               cnt_known = 1'b0;

  function automatic bit reads(input logic [4:0] rd);
    return (rd != 5'd0) && ((useRs1_ID && rs1_ID == rd) || (useRs2_ID && rs2_ID == rd));
  endfunction

  function automatic int needed_bubbles();
    if (isBJ_ID && memRead_EX && reads(rd_EX)) return 2;
    if ((memRead_EX && reads(rd_EX)) ||
        (isBJ_ID && regWrite_EX && !memRead_EX && reads(rd_EX)) ||
        (isBJ_ID && memRead_MEM && reads(rd_MEM))) return 1;
    return 0;
  endfunction

  always @(negedge clk) begin
    logic [6:0] exp_v;
    bit frozen;
    int need;
    if (cnt_known) begin
      check("stallCycles", stallCycles, PERF ? m_stall : '0);
      check("flushCount",  flushCount,  PERF ? m_flush : '0);
    end
    need   = needed_bubbles();
    frozen = m_wait ? !dmem_ready : (dmem_req && !dmem_ready);
    if (rst)              exp_v = V_RESET;
    else if (frozen)      exp_v = V_FREEZE;
    else if (m_left > 0)  exp_v = V_BUBBLE;
    else if (need > 0)    exp_v = V_BUBBLE;
    else if (bjTaken_ID)  exp_v = V_TAKEN;
    else                  exp_v = V_RUN;
    check("ctl", {57'd0, ctl_vec}, {57'd0, exp_v});

    if (rst) begin
      m_wait = 1'b0; m_left = 0; m_stall = '0; m_flush = '0; cnt_known = 1'b1;
    end else begin
      if (frozen) m_wait = 1'b1;
      else begin
        m_wait = 1'b0;
        if (m_left > 0)     m_left--;
        else if (need > 0)  m_left = need - 1;
      end
      if (!exp_v[6]) m_stall = m_stall + 1'b1;
      if (exp_v[1])  m_flush = m_flush + 1'b1;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    rs1_ID = 5'd0; rs2_ID = 5'd0; useRs1_ID = 1'b0; useRs2_ID = 1'b0;
    isBJ_ID = 1'b0; bjTaken_ID = 1'b0;
    rd_EX = 5'd0; regWrite_EX = 1'b0; memRead_EX = 1'b0;
    rd_MEM = 5'd0; memRead_MEM = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
  endtask

  // Advance to just after the next rising edge; inputs set afterwards hold for one cycle.
  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  // Literal check taken mid-cycle, well away from both clock edges.
  task automatic expect_ctl(input string name, input logic [6:0] v);
    #3;
    check(name, {57'd0, ctl_vec}, {57'd0, v});
  endtask

  task automatic do_reset();
    rst = 1'b1; idle();
    next_cycle();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; idle();
    // reset state
    #2 check("reset_ctl", {57'd0, ctl_vec}, {57'd0, V_RESET});
    next_cycle(); next_cycle();
    rst = 1'b0;
    expect_ctl("run_after_reset", V_RUN);
    check("stall_after_reset", stallCycles, '0);
    check("flush_after_reset", flushCount, '0);

    // load-use: lw x5 in EX, add reads x5
    next_cycle(); idle();
    rd_EX = 5'd5; memRead_EX = 1'b1; regWrite_EX = 1'b1; rs1_ID = 5'd5; useRs1_ID = 1'b1;
    expect_ctl("luse_bubble", V_BUBBLE);
    next_cycle(); idle();
    expect_ctl("luse_after", V_RUN);

    // lw x6 in EX, taken beq x6,x0 -> two bubbles then flush
    next_cycle(); idle();
    rd_EX = 5'd6; memRead_EX = 1'b1; regWrite_EX = 1'b1;
    rs1_ID = 5'd6; useRs1_ID = 1'b1; useRs2_ID = 1'b1; isBJ_ID = 1'b1; bjTaken_ID = 1'b1;
    expect_ctl("bjld_bubble1", V_BUBBLE);
    next_cycle();
    rd_EX = 5'd0; memRead_EX = 1'b0; regWrite_EX = 1'b0; rd_MEM = 5'd6; memRead_MEM = 1'b1;
    expect_ctl("bjld_bubble2", V_BUBBLE);
    next_cycle();
    rd_MEM = 5'd0; memRead_MEM = 1'b0;
    expect_ctl("bjld_taken_flush", V_TAKEN);

    // addi x7 in EX, beq x7 in ID; then rd_EX = x0
    next_cycle(); idle();
    rd_EX = 5'd7; regWrite_EX = 1'b1; rs2_ID = 5'd7; useRs2_ID = 1'b1; isBJ_ID = 1'b1;
    expect_ctl("bjex_bubble", V_BUBBLE);
    next_cycle();
    rd_EX = 5'd0; rs2_ID = 5'd0;
    expect_ctl("bjex_x0_none", V_RUN);

    // load in MEM feeding a branch -> one bubble
    next_cycle(); idle();
    rd_MEM = 5'd9; memRead_MEM = 1'b1; rs1_ID = 5'd9; useRs1_ID = 1'b1; isBJ_ID = 1'b1;
    expect_ctl("bjldmem_bubble", V_BUBBLE);
    next_cycle(); idle();
    expect_ctl("bjldmem_after", V_RUN);

    // freeze during STALL: 3 frozen cycles, then the remaining bubble, then RUN
    next_cycle(); idle();
    rd_EX = 5'd6; memRead_EX = 1'b1; rs1_ID = 5'd6; useRs1_ID = 1'b1; isBJ_ID = 1'b1;
    expect_ctl("stall_entry", V_BUBBLE);
    for (int i = 0; i < 3; i++) begin
      next_cycle(); idle(); dmem_req = 1'b1; dmem_ready = 1'b0;
      expect_ctl("stall_freeze", V_FREEZE);
    end
    next_cycle(); dmem_ready = 1'b1;
    expect_ctl("stall_release_bubble", V_BUBBLE);
    next_cycle(); idle();
    expect_ctl("stall_back_to_run", V_RUN);

    // freeze and hazard together: freeze wins, hazard resolved after release
    next_cycle(); idle();
    dmem_req = 1'b1; rd_EX = 5'd3; memRead_EX = 1'b1; rs2_ID = 5'd3; useRs2_ID = 1'b1;
    expect_ctl("freeze_wins", V_FREEZE);
    next_cycle(); dmem_ready = 1'b1;
    expect_ctl("release_hazard_bubble", V_BUBBLE);

    // reset in the middle of MEM_WAIT
    next_cycle(); idle(); dmem_req = 1'b1;
    expect_ctl("wait_enter", V_FREEZE);
    next_cycle(); rst = 1'b1;
    expect_ctl("reset_in_wait", V_RESET);
    next_cycle(); rst = 1'b0; idle();
    expect_ctl("run_after_wait_reset", V_RUN);
    check("stall_cleared", stallCycles, '0);
    check("flush_cleared", flushCount, '0);

    // counters: 5 bubbles + 2 freezes + 3 taken branches
    next_cycle(); do_reset();
    for (int i = 0; i < 5; i++) begin
      next_cycle(); idle(); rd_EX = 5'd12; memRead_EX = 1'b1; rs1_ID = 5'd12; useRs1_ID = 1'b1;
    end
    next_cycle(); idle(); dmem_req = 1'b1;
    next_cycle();
    next_cycle(); dmem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      next_cycle(); idle(); isBJ_ID = 1'b1; bjTaken_ID = 1'b1;
    end
    next_cycle(); idle();
    #3;
    check("perf_stallCycles", stallCycles, PERF ? 64'd7 : 64'd0);
    check("perf_flushCount",  flushCount,  PERF ? 64'd3 : 64'd0);

    // randomized traffic with small register numbers so hazards are frequent
    for (int i = 0; i < 4000; i++) begin
      next_cycle();
      rst         = ($urandom_range(0, 199) == 0);
      rs1_ID      = 5'($urandom_range(0, 3));
      rs2_ID      = 5'($urandom_range(0, 3));
      useRs1_ID   = 1'($urandom_range(0, 1));
      useRs2_ID   = 1'($urandom_range(0, 1));
      isBJ_ID     = ($urandom_range(0, 2) == 0);
      bjTaken_ID  = isBJ_ID && 1'($urandom_range(0, 1));
      rd_EX       = 5'($urandom_range(0, 3));
      memRead_EX  = ($urandom_range(0, 2) == 0);
      regWrite_EX = memRead_EX || 1'($urandom_range(0, 1));
      rd_MEM      = 5'($urandom_range(0, 3));
      memRead_MEM = ($urandom_range(0, 2) == 0);
      dmem_req    = ($urandom_range(0, 3) == 0);
      dmem_ready  = 1'($urandom_range(0, 1));
    end

    next_cycle(); rst = 1'b0; idle();
    next_cycle();
    @(negedge clk); #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
